// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 3-bit seven-segment encode/decode family.
// SEG_CODE must stay identical to the encoder's output table so that
// loopback checking compares like with like.
package seven_seg_pkg;

   localparam int SEG_W     = 8;   // bit7=a .. bit1=g, bit0=dp
   localparam int VAL_W     = 3;   // decoded digit value width
   localparam int NUM_CODES = 8;   // one pattern per 3-bit value

   // Segment pattern for each value; dp (bit0) is always clear.
   localparam logic [SEG_W-1:0] SEG_CODE [0:NUM_CODES-1] = '{
      8'hFC,   // 0
      8'h60,   // 1
      8'hDA,   // 2
      8'hF2,   // 3
      8'h66,   // 4
      8'hB6,   // 5
      8'hBE,   // 6
      8'hE0    // 7
   };

   // Scan reader dwell tracking states.
   typedef enum logic [1:0] {
      ST_BLANK    = 2'd0,   // strobe idle or illegal (not one-hot)
      ST_SETTLE   = 2'd1,   // one-hot strobe, waiting for stability
      ST_CAPTURED = 2'd2    // this dwell has already been captured
   } scan_state_e;

endpackage : seven_seg_pkg

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational inverse of the 3-bit segment encoder.
// All eight bits (including dp) must match a table entry exactly for a hit;
// on a miss the value output is driven to zero and must be ignored.
module seven_segment_pattern_decoder
   import seven_seg_pkg::*;
(
   input  logic [SEG_W-1:0] pattern_i,
   output logic             hit_o,
   output logic [VAL_W-1:0] value_o
);

   // Exact-match search over the code table; codes are unique so at most one hits.
   always_comb begin
      hit_o   = 1'b0;
      value_o = '0;
      for (int k = 0; k < NUM_CODES; k++) begin
         if (pattern_i == SEG_CODE[k]) begin
            hit_o   = 1'b1;
            value_o = VAL_W'(k);
         end
      end
   end

endmodule : seven_segment_pattern_decoder

// File: rtl/seven_segment_scan_reader.sv
// Recovers per-digit 3-bit values from a time-multiplexed seven-segment bus.
// Inputs are sampled every cycle; a dwell (pattern + one-hot strobe) is
// captured once, after STABLE_CYCLES identical consecutive samples.
// Illegal patterns flag Err_out for that digit and leave its value alone.
// Frame_done pulses when every digit has been captured since the last pulse.
module seven_segment_scan_reader
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
)(
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [SEG_W-1:0]            Seg_in,
   input  logic [NUM_DIGITS-1:0]       Anode_in,
   output logic [VAL_W*NUM_DIGITS-1:0] Value_out,
   output logic [NUM_DIGITS-1:0]       Valid_out,
   output logic [NUM_DIGITS-1:0]       Err_out,
   output logic                        Frame_done
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   // Position of the single set bit; only meaningful for a one-hot argument.
   function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (v[k]) begin
            idx = IDX_W'(k);
         end
      end
      return idx;
   endfunction

   // Sample registers and stability tracking
   logic [SEG_W-1:0]      seg_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   scan_state_e           state_q, state_d;

   // Output and frame-tracking registers
   logic [VAL_W*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]       valid_q, valid_d;
   logic [NUM_DIGITS-1:0]       err_q, err_d;
   logic [NUM_DIGITS-1:0]       mask_q, mask_d;
   logic                        frame_q, frame_d;

   // Combinational helpers
   logic             change;
   logic             an_q_onehot;
   logic             an_in_onehot;
   logic             capture;
   logic [IDX_W-1:0] dig_idx;
   logic             dec_hit;
   logic [VAL_W-1:0] dec_val;

   // The captured pattern is the registered sample, which equals the live
   // input whenever a capture is allowed (no change on that edge).
   seven_segment_pattern_decoder u_decoder (
      .pattern_i (seg_q),
      .hit_o     (dec_hit),
      .value_o   (dec_val)
   );

   // Stability counter and dwell FSM next-state; an input change always
   // restarts settling, even on the edge the counter would otherwise fire.
   always_comb begin
      change       = (Seg_in != seg_q) || (Anode_in != an_q);
      an_q_onehot  = $onehot(an_q);
      an_in_onehot = $onehot(Anode_in);
      dig_idx      = onehot_index(an_q);
      capture      = 1'b0;
      state_d      = state_q;

      if (change) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (change) begin
         state_d = an_in_onehot ? ST_SETTLE : ST_BLANK;
      end else if (!an_q_onehot) begin
         state_d = ST_BLANK;
      end else if (cnt_q == CNT_MAX) begin
         // One capture per dwell: only the first saturated cycle captures.
         capture = (state_q != ST_CAPTURED);
         state_d = ST_CAPTURED;
      end else begin
         state_d = ST_SETTLE;
      end
   end

   // Per-digit output update on capture plus frame mask bookkeeping.
   always_comb begin
      value_d = value_q;
      valid_d = valid_q;
      err_d   = err_q;
      mask_d  = mask_q;
      frame_d = 1'b0;

      if (capture) begin
         if (dec_hit) begin
            value_d[VAL_W*int'(dig_idx) +: VAL_W] = dec_val;
            valid_d[dig_idx] = 1'b1;
            err_d[dig_idx]   = 1'b0;
         end else begin
            // Keep the last good value; only the flags report the miss.
            valid_d[dig_idx] = 1'b0;
            err_d[dig_idx]   = 1'b1;
         end
         mask_d[dig_idx] = 1'b1;
         if (&mask_d) begin
            frame_d = 1'b1;
            mask_d  = '0;
         end
      end
   end

   // State register: full clear on reset so a held dwell must settle again.
   always_ff @(posedge CLK) begin
      if (RST) begin
         seg_q   <= '0;
         an_q    <= '0;
         cnt_q   <= '0;
         state_q <= ST_BLANK;
         value_q <= '0;
         valid_q <= '0;
         err_q   <= '0;
         mask_q  <= '0;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= Seg_in;
         an_q    <= Anode_in;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         value_q <= value_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         frame_q <= frame_d;
      end
   end

   assign Value_out  = value_q;
   assign Valid_out  = valid_q;
   assign Err_out    = err_q;
   assign Frame_done = frame_q;

endmodule : seven_segment_scan_reader

// File: tb/tb_seven_segment_scan_reader.sv
// Self-checking bench for seven_segment_scan_reader (default parameters).
// Each task drives dwells, pushes the expected output state to a scoreboard
// queue and pops/compares it once the DUT is due to have produced it.
module tb_seven_segment_scan_reader;

   localparam int ND = 4;

   // Expected output snapshot: {Value, Valid, Err, Frame}
   typedef struct packed {
      logic [3*ND-1:0] v;
      logic [ND-1:0]   vl;
      logic [ND-1:0]   e;
      logic            f;
   } exp_t;

   // Independent copy of the encoder's pattern table
   localparam logic [7:0] TB_CODES [8] = '{8'hFC, 8'h60, 8'hDA, 8'hF2,
                                           8'h66, 8'hB6, 8'hBE, 8'hE0};

   logic            CLK = 1'b0;
   logic            RST;
   logic [7:0]      Seg_in;
   logic [ND-1:0]   Anode_in;
   logic [3*ND-1:0] Value_out;
   logic [ND-1:0]   Valid_out;
   logic [ND-1:0]   Err_out;
   logic            Frame_done;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t exp_s;
   exp_t obs_s;

   // Bench-side expected state of the outputs and the frame mask
   logic [3*ND-1:0] m_val  = '0;
   logic [ND-1:0]   m_vld  = '0;
   logic [ND-1:0]   m_err  = '0;
   logic [ND-1:0]   m_mask = '0;

   seven_segment_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(3)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Seg_in     (Seg_in),
      .Anode_in   (Anode_in),
      .Value_out  (Value_out),
      .Valid_out  (Valid_out),
      .Err_out    (Err_out),
      .Frame_done (Frame_done)
   );

   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drive(input logic [7:0] s, input logic [ND-1:0] a);
      Seg_in   = s;
      Anode_in = a;
   endtask

   task automatic model_clear();
      m_val  = '0;
      m_vld  = '0;
      m_err  = '0;
      m_mask = '0;
   endtask

   function automatic exp_t model_idle();
      exp_t r;
      r.v  = m_val;
      r.vl = m_vld;
      r.e  = m_err;
      r.f  = 1'b0;
      return r;
   endfunction

   function automatic exp_t model_capture(input logic [7:0] seg, input int d);
      exp_t       r;
      logic       hit;
      logic [2:0] val;
      hit = 1'b0;
      val = '0;
      for (int k = 0; k < 8; k++) begin
         if (seg == TB_CODES[k]) begin
            hit = 1'b1;
            val = 3'(k);
         end
      end
      if (hit) begin
         m_val[3*d +: 3] = val;
         m_vld[d] = 1'b1;
         m_err[d] = 1'b0;
      end else begin
         m_vld[d] = 1'b0;
         m_err[d] = 1'b1;
      end
      m_mask[d] = 1'b1;
      r.f = 1'b0;
      if (m_mask == '1) begin
         r.f    = 1'b1;
         m_mask = '0;
      end
      r.v  = m_val;
      r.vl = m_vld;
      r.e  = m_err;
      return r;
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      drive(8'h00, '0);
      step(2);
      RST = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      drive(8'hFC, 4'b0001);
      step(2);
      model_clear();
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", obs_s, exp_s);
      end
      RST = 1'b0;
      step(3);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL reset_release_early got=%h exp=%h", obs_s, exp_s);
      end
      step(1);
      sb.push_back(model_capture(8'hFC, 0));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL reset_release_capture got=%h exp=%h", obs_s, exp_s);
      end
   endtask

   task automatic test_scan();
      logic [7:0] pats [4];
      pats = '{8'hF2, 8'h66, 8'hE0, 8'h60};
      do_reset();
      for (int d = 0; d < ND; d++) begin
         drive(pats[d], ND'(1) << d);
         step(3);
         sb.push_back(model_idle());
         obs_s = {Value_out, Valid_out, Err_out, Frame_done};
         exp_s = sb.pop_front();
         checks++;
         if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL scan_settle d%0d got=%h exp=%h", d, obs_s, exp_s);
         end
         step(1);
         sb.push_back(model_capture(pats[d], d));
         obs_s = {Value_out, Valid_out, Err_out, Frame_done};
         exp_s = sb.pop_front();
         checks++;
         if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL scan_capture d%0d got=%h exp=%h", d, obs_s, exp_s);
         end
      end
      checks++;
      if (Value_out !== 12'b001_111_100_011 || Valid_out !== 4'b1111 || Frame_done !== 1'b1) begin
         failures++;
         $display("FAIL scan_final got=%b/%b/%b exp=001111100011/1111/1",
                  Value_out, Valid_out, Frame_done);
      end
      step(1);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL scan_frame_single got=%h exp=%h", obs_s, exp_s);
      end
   endtask

   task automatic test_short_dwell();
      int frames;
      frames = 0;
      do_reset();
      drive(8'hB6, 4'b0010);
      step(2);
      drive(8'h00, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (Frame_done === 1'b1) frames++;
         sb.push_back(model_idle());
         obs_s = {Value_out, Valid_out, Err_out, Frame_done};
         exp_s = sb.pop_front();
         checks++;
         if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL short_dwell c%0d got=%h exp=%h", i, obs_s, exp_s);
         end
      end
      checks++;
      if (frames != 0) begin
         failures++;
         $display("FAIL short_dwell_frame got=%0d exp=0", frames);
      end
   endtask

   task automatic test_dp_error();
      do_reset();
      drive(8'hDA, 4'b0100);
      step(4);
      sb.push_back(model_capture(8'hDA, 2));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL dp_prefill got=%h exp=%h", obs_s, exp_s);
      end
      drive(8'h00, 4'b0000);
      step(1);
      drive(8'hFD, 4'b0100);
      step(3);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL dp_settle got=%h exp=%h", obs_s, exp_s);
      end
      step(1);
      sb.push_back(model_capture(8'hFD, 2));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL dp_error got=%h exp=%h", obs_s, exp_s);
      end
      checks++;
      if (Value_out[8:6] !== 3'd2 || Err_out[2] !== 1'b1 || Valid_out[2] !== 1'b0) begin
         failures++;
         $display("FAIL dp_value_kept got=%0d/%b/%b exp=2/1/0",
                  Value_out[8:6], Err_out[2], Valid_out[2]);
      end
      drive(8'hB6, 4'b0100);
      step(4);
      sb.push_back(model_capture(8'hB6, 2));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL dp_recover got=%h exp=%h", obs_s, exp_s);
      end
   endtask

   task automatic test_multi_strobe();
      do_reset();
      drive(8'hDA, 4'b0011);
      for (int i = 0; i < 10; i++) begin
         step(1);
         sb.push_back(model_idle());
         obs_s = {Value_out, Valid_out, Err_out, Frame_done};
         exp_s = sb.pop_front();
         checks++;
         if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL multi_strobe c%0d got=%h exp=%h", i, obs_s, exp_s);
         end
      end
      drive(8'hDA, 4'b0100);
      step(3);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL onehot_settle got=%h exp=%h", obs_s, exp_s);
      end
      step(1);
      sb.push_back(model_capture(8'hDA, 2));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL onehot_capture got=%h exp=%h", obs_s, exp_s);
      end
      step(5);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL onehot_hold got=%h exp=%h", obs_s, exp_s);
      end
   endtask

   task automatic test_reset_mid_dwell();
      do_reset();
      drive(8'h66, 4'b0001);
      step(2);
      RST = 1'b1;
      step(1);
      model_clear();
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL mid_reset_clear got=%h exp=%h", obs_s, exp_s);
      end
      RST = 1'b0;
      step(3);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL mid_reset_early got=%h exp=%h", obs_s, exp_s);
      end
      step(1);
      sb.push_back(model_capture(8'h66, 0));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL mid_reset_capture got=%h exp=%h", obs_s, exp_s);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]    pats [3];
      logic [ND-1:0] ans  [3];
      pats = '{8'h60, 8'hE0, 8'hBE};
      ans  = '{4'b0010, 4'b1000, 4'b0100};
      do_reset();
      // Change arrives on the edge the counter saturates: no capture.
      drive(8'hFC, 4'b0001);
      step(3);
      drive(8'h60, 4'b0001);
      step(1);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL change_wins got=%h exp=%h", obs_s, exp_s);
      end
      step(2);
      sb.push_back(model_idle());
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL change_resettle got=%h exp=%h", obs_s, exp_s);
      end
      step(1);
      sb.push_back(model_capture(8'h60, 0));
      obs_s = {Value_out, Valid_out, Err_out, Frame_done};
      exp_s = sb.pop_front();
      checks++;
      if (obs_s !== exp_s) begin
         failures++;
         $display("FAIL change_capture got=%h exp=%h", obs_s, exp_s);
      end
      // Same pattern on a new digit, then out-of-order 3, 2 to finish a frame.
      for (int i = 0; i < 3; i++) begin
         drive(pats[i], ans[i]);
         step(3);
         sb.push_back(model_idle());
         obs_s = {Value_out, Valid_out, Err_out, Frame_done};
         exp_s = sb.pop_front();
         checks++;
         if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL b2b_settle i%0d got=%h exp=%h", i, obs_s, exp_s);
         end
         step(1);
         sb.push_back(model_capture(pats[i], $clog2(int'(ans[i]))));
         obs_s = {Value_out, Valid_out, Err_out, Frame_done};
         exp_s = sb.pop_front();
         checks++;
         if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL b2b_capture i%0d got=%h exp=%h", i, obs_s, exp_s);
         end
      end
   endtask

   initial begin
      RST      = 1'b1;
      Seg_in   = 8'h00;
      Anode_in = '0;
      test_reset();
      test_scan();
      test_short_dwell();
      test_dp_error();
      test_multi_strobe();
      test_reset_mid_dwell();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seven_segment_scan_reader
